// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS PC sequencer
//
// Purpose: sequencer state encoding, the default reset and halt addresses,
// and the instruction word width, shared by RTL and bench.
package mips_pkg;

  localparam int          INSTR_W              = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mips_pc_sequencer.sv
// rtl/mips_pc_sequencer.sv - fetch/execute sequencer and PC/delay-slot registers
//
// Purpose: steps a multi-cycle MIPS core through FETCH -> EXEC (-> MEM_WAIT)
// and retires one instruction per pass, tracking the branch delay slot.
// Configuration macro: ALIGN_CHECK_EN (halt with fault on misaligned redirect).
//
// Ports:
//   clk, reset, clk_enable  - clock, sync active-high reset, global enable
//   waitrequest             - memory not ready for fetch or data access
//   instr_readdata          - fetched instruction word
//   mem_access              - current instruction is a load/store
//   redirect, redirect_target - taken branch/jump and its target
//   instr_address           - current PC
//   ir                      - latched instruction register
//   delay_slot              - next PC to fetch
//   link_address            - delay_slot + 4
//   fetch, commit, active, fault - status strobes
module mips_pc_sequencer
  import mips_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(DEFAULT_HALT_ADDR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic               waitrequest,
  input  logic [INSTR_W-1:0] instr_readdata,
  input  logic               mem_access,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  instr_address,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  delay_slot,
  output logic [ADDR_W-1:0]  link_address,
  output logic               fetch,
  output logic               commit,
  output logic               active,
  output logic               fault
);

  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

  seq_state_e         state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  ds_q;
  logic [ADDR_W-1:0]  ds_d;
  logic [INSTR_W-1:0] ir_q;
  logic               retire;
  logic               misaligned;

  // A non-memory instruction retires in its first EXEC cycle whatever
  // waitrequest says; a memory one retires once waitrequest drops.
  assign retire = ((state_q == ST_EXEC) && (!mem_access || !waitrequest)) ||
                  ((state_q == ST_MEM_WAIT) && !waitrequest);

  // Wraps modulo 2^ADDR_W naturally.
  assign ds_d = redirect ? redirect_target : ds_q + WORD;

`ifdef ALIGN_CHECK_EN
  logic fault_q;
  assign misaligned = redirect && (redirect_target[1:0] != 2'b00);
  assign fault      = fault_q;
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clk_enable) begin
      if (reset) begin
        state_q <= ST_FETCH;
        pc_q    <= RESET_VECTOR;
        ds_q    <= RESET_VECTOR + WORD;
        ir_q    <= '0;
`ifdef ALIGN_CHECK_EN
        fault_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_FETCH: begin
            if (!waitrequest) begin
              ir_q    <= instr_readdata;
              state_q <= ST_EXEC;
            end
          end
          ST_EXEC, ST_MEM_WAIT: begin
            if (retire) begin
              pc_q <= ds_q;
              if (misaligned) begin
                // Keep the delay slot so the offending branch can be inspected.
                state_q <= ST_HALT;
`ifdef ALIGN_CHECK_EN
                fault_q <= 1'b1;
`endif
              end else begin
                ds_q    <= ds_d;
                state_q <= (pc_q == HALT_ADDR) ? ST_HALT : ST_FETCH;
              end
            end else begin
              state_q <= ST_MEM_WAIT;
            end
          end
          ST_HALT: state_q <= ST_HALT;
          default: state_q <= ST_FETCH;
        endcase
      end
    end
  end

  // Reset and a disabled clock both suppress the write strobe.
  assign commit        = clk_enable && !reset && retire;
  assign fetch         = (state_q == ST_FETCH);
  assign active        = (state_q != ST_HALT);
  assign instr_address = pc_q;
  assign delay_slot    = ds_q;
  assign link_address  = ds_q + WORD;
  assign ir            = ir_q;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// tb/tb_mips_pc_sequencer.sv - scoreboard bench for the MIPS PC sequencer
module tb_mips_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0, clk_enable = 1'b0, waitrequest = 1'b0;
  logic        mem_access = 1'b0, redirect = 1'b0;
  logic [31:0] instr_readdata = '0, redirect_target = '0;
  logic [31:0] instr_address, ir, delay_slot, link_address;
  logic        fetch, commit, active, fault;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit stall_en = 1'b0;

  // Architectural model: program counter, next fetch address, halted flag.
  logic [31:0] m_pc, m_ds;
  bit          m_halt;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ds;
  } exp_t;
  exp_t sb[$];

  mips_pc_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .waitrequest(waitrequest),
    .instr_readdata(instr_readdata), .mem_access(mem_access), .redirect(redirect),
    .redirect_target(redirect_target), .instr_address(instr_address), .ir(ir),
    .delay_slot(delay_slot), .link_address(link_address), .fetch(fetch),
    .commit(commit), .active(active), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every commit strobe must match the oldest planned retire.
  always @(negedge clk) begin
    if (commit !== 1'b0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit actual=commit at pc %h required=no commit", instr_address);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_cycle", cyc, e.cyc);
        check("commit_pc", instr_address, e.pc);
        check("commit_ir", ir, e.ir);
        check("commit_delay_slot", delay_slot, e.ds);
        check("commit_link", link_address, e.ds + 32'd4);
      end
    end
  end

  // One enabled cycle, optionally preceded by a frozen cycle with garbage inputs.
  task automatic cycle(input logic w, input logic [31:0] rd, input logic ma,
                       input logic rdr, input logic [31:0] tg, input bit push,
                       input logic [31:0] e_ir);
    if (stall_en && $urandom_range(0, 5) == 0) begin
      clk_enable = 1'b0; reset = rb(); waitrequest = rb();
      instr_readdata = $urandom; mem_access = rb(); redirect = rb();
      redirect_target = $urandom;
      @(posedge clk); #1;
    end
    clk_enable = 1'b1; reset = 1'b0; waitrequest = w; instr_readdata = rd;
    mem_access = ma; redirect = rdr; redirect_target = tg;
    if (push) sb.push_back('{cyc, m_pc, e_ir, m_ds});
    @(posedge clk); #1;
  endtask

  // One instruction: fw fetch stalls, fetch, ew data stalls, retire.
  task automatic run_instr(input bit ma, input int fw, input int ew, input bit rdr,
                           input logic [31:0] tg, input logic [31:0] word);
    for (int i = 0; i < fw; i++) cycle(1'b1, $urandom, rb(), rb(), $urandom, 1'b0, '0);
    cycle(1'b0, word, rb(), rb(), $urandom, 1'b0, '0);
    if (ma) for (int i = 0; i < ew; i++) cycle(1'b1, $urandom, 1'b1, rb(), $urandom, 1'b0, '0);
    cycle(ma ? 1'b0 : rb(), $urandom, ma, rdr, tg, 1'b1, word);
`ifdef ALIGN_CHECK_EN
    if (rdr && tg[1:0] != 2'b00) begin
      m_pc = m_ds;
      m_halt = 1'b1;
      return;
    end
`endif
    if (m_pc == 32'h0) m_halt = 1'b1;
    m_pc = m_ds;
    m_ds = rdr ? tg : m_ds + 32'd4;
  endtask

  task automatic do_reset();
    clk_enable = 1'b1; reset = 1'b1; waitrequest = rb(); mem_access = rb();
    redirect = rb(); redirect_target = $urandom; instr_readdata = $urandom;
    @(posedge clk); #1;
    reset = 1'b0; waitrequest = 1'b1;
    m_pc = RV; m_ds = RV + 32'd4; m_halt = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ds0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    #1;
    check("rst_pc", instr_address, RV);
    check("rst_ds", delay_slot, RV + 32'd4);
    check("rst_link", link_address, RV + 32'd8);
    check("rst_ir", ir, 32'h0);
    check("rst_fetch", {31'b0, fetch}, 32'd1);
    check("rst_active", {31'b0, active}, 32'd1);
    check("rst_commit", {31'b0, commit}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);

    // Back-to-back two-cycle instructions.
    run_instr(1'b0, 0, 0, 1'b0, '0, 32'h2408_0001);
    run_instr(1'b0, 0, 0, 1'b0, '0, 32'h2409_0002);
    check("seq_pc", instr_address, RV + 32'd8);

    // Redirect takes effect after the delay slot.
    do_reset();
    run_instr(1'b0, 0, 0, 1'b1, 32'hBFC0_0100, 32'h1000_003F);
    check("delay_slot_pc", instr_address, RV + 32'd4);
    run_instr(1'b0, 0, 0, 1'b0, '0, 32'h0000_0000);
    check("redir_pc", instr_address, 32'hBFC0_0100);
    run_instr(1'b0, 0, 0, 1'b0, '0, 32'h2401_0003);

    // Fetch stalls then data stalls.
    do_reset();
    run_instr(1'b1, 3, 2, 1'b0, '0, 32'h8C22_0000);
    run_instr(1'b1, 0, 0, 1'b0, '0, 32'hAC22_0004);

    // Randomized traffic with frozen cycles interleaved.
    do_reset();
    stall_en = 1'b1;
    repeat (150) begin
      run_instr(rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3) == 0,
                RV + ($urandom_range(0, 1023) << 2), $urandom);
    end
    stall_en = 1'b0;

    // Misaligned redirect.
    do_reset();
    ds0 = m_ds;
    run_instr(1'b0, 0, 0, 1'b1, 32'hBFC0_0102, 32'h0810_0040);
`ifdef ALIGN_CHECK_EN
    check("align_fault", {31'b0, fault}, 32'd1);
    check("align_active", {31'b0, active}, 32'd0);
    check("align_ds", delay_slot, ds0);
`else
    check("align_fault", {31'b0, fault}, 32'd0);
    check("align_ds", delay_slot, 32'hBFC0_0102);
    check("align_ds_prev", ds0 + 32'd4, instr_address + 32'd4);
`endif

    // Wrap past the top of the address space into HALT_ADDR.
    do_reset();
    run_instr(1'b0, 0, 0, 1'b1, 32'hFFFF_FFFC, 32'h0BFF_FFFF);
    run_instr(1'b0, 0, 0, 1'b0, '0, 32'h0000_0000);
    run_instr(1'b1, 1, 1, 1'b0, '0, 32'h8C01_0000);
    run_instr(1'b0, 0, 0, 1'b0, '0, 32'h0000_000D);
    check("halt_active_next", {31'b0, active}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(rb(), $urandom, rb(), rb(), $urandom, 1'b0, '0);
      check("halt_active", {31'b0, active}, 32'd0);
      check("halt_fetch", {31'b0, fetch}, 32'd0);
    end
    do_reset();
    check("halt_reset_pc", instr_address, RV);
    check("halt_reset_active", {31'b0, active}, 32'd1);

    // Reset wins over a retire out of MEM_WAIT.
    cycle(1'b0, 32'h8C03_0000, 1'b0, 1'b0, '0, 1'b0, '0);
    cycle(1'b1, $urandom, 1'b1, 1'b0, '0, 1'b0, '0);
    clk_enable = 1'b1; reset = 1'b1; waitrequest = 1'b0; mem_access = 1'b1;
    redirect = 1'b1; redirect_target = 32'hBFC0_0200;
    #1;
    check("memwait_reset_commit", {31'b0, commit}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; waitrequest = 1'b1;
    m_pc = RV; m_ds = RV + 32'd4; m_halt = 1'b0;
    #1;
    check("memwait_reset_pc", instr_address, RV);
    check("memwait_reset_ds", delay_slot, RV + 32'd4);
    check("memwait_reset_fetch", {31'b0, fetch}, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
